sub4u_serial_inverse: RTL and testbench
=======================================

# sub4u_serial_inverse

Bit-serial unsigned inverse of the 4-bit unsigned adder: given a 5-bit sum S and one 4-bit operand A, it recovers the other operand B = S − A. It is used on the checking side of the fault-resilient adder datapath to reconstruct B from the adder's O[4:0] and A, so that the result can be compared with the original B. A valid/ready handshake wraps a 5-step LSB-first borrow-ripple subtract. An error flag reports sums that no 4-bit B can produce.

## Interface
- No parameters; widths are fixed at 4-bit operands and a 5-bit sum.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  S/A present this cycle
- in_ready  out  1  block can accept a new S/A
- s  in  5  sum word, O[4:0] of the adder, unsigned
- a  in  4  known operand A[3:0], unsigned
- out_valid  out  1  result b/err valid
- out_ready  in  1  consumer accepts the result
- b  out  4  recovered operand B[3:0]
- err  out  1  S < A, or S − A > 15

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch s into 5-bit shift register sr, latch {1'b0,a} into ar, borrow=0, bit counter cnt=0, go to SHIFT.
- SHIFT, one bit per clock, LSB first:
  - d = sr[0] ^ ar[0] ^ borrow
  - borrow_next = (~sr[0] & ar[0]) | (~(sr[0] ^ ar[0]) & borrow)
  - Shift d into result register rr from the MSB side; shift sr and ar right by one.
  - cnt increments. After cnt reaches 4 (the 5th bit is processed), go to DONE.
- DONE:
  - out_valid=1.
  - b = rr[3:0].
  - err = final borrow | rr[4].
  - Hold b and err stable until out_valid&out_ready, then return to IDLE.
- in_ready=0 in SHIFT and DONE. in_valid is ignored there; the source must hold its data.
- Arithmetic:
  - 5-bit modular subtract.
  - Final borrow=1 means S < A.
  - rr[4]=1 with no borrow means S − A ≥ 16.
  - b always equals (S − A) mod 16, including when err=1.
- No back-to-back overlap. A new input is accepted only in IDLE, so the throughput is one result per 7 cycles when out_ready is tied high.

## Timing
- Reset:
  - State=IDLE.
  - in_ready=1, out_valid=0, b=0, err=0.
  - sr, ar, rr, borrow and cnt are all cleared.
- Handshake at edge k:
  - SHIFT occupies edges k+1 … k+5.
  - out_valid rises after edge k+5.
  - Latency is 6 cycles from accept to first valid output.
- If out_ready=1 while out_valid=1: the transfer completes at that edge. in_ready is 1 in the following cycle, and out_valid drops at the same edge.
- If out_ready is held low, DONE persists indefinitely and b/err do not change.
- Whenever out_valid=1, in_ready=0. Accept and output never complete in the same edge.
- rst_n asserted mid-SHIFT or mid-DONE:
  - Outputs clear immediately (asynchronously).
  - The in-flight result is discarded.
  - After release the FSM is in IDLE.
- b and err are registered. They update only on the SHIFT→DONE edge and are otherwise held. b is not cleared on leaving DONE; it keeps its last value until the next DONE.

## Test plan
- Reset and nominal case:
  - Stimulus: reset, then s=5'd19, a=4'd7, out_ready=1.
  - Required: in_ready drops one cycle after accept; out_valid rises 6 cycles after accept with b=12, err=0; in_ready=1 in the next cycle.
- Extremes:
  - s=5'd30, a=4'd15 → b=15, err=0.
  - s=0, a=0 → b=0, err=0.
- Underflow: s=5'd3, a=4'd9 → err=1, b=10 (i.e. (3−9) mod 16).
- Overflow: s=5'd20, a=4'd2 → err=1, b=2 (18 mod 16).
- Backpressure:
  - Stimulus: after s=5'd10, a=4'd4, hold out_ready=0 for 8 cycles while toggling in_valid with new data.
  - Required: out_valid stays 1, b stays 6, in_ready stays 0; after out_ready=1, the next accept takes the new data.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 two cycles into SHIFT.
  - Required: out_valid=0, in_ready=1 and b=0 immediately; after release, a fresh s=5'd16, a=4'd1 yields b=15, err=0.

Source files
------------

// File: rtl/sub4u_serial_inverse_if.sv
// Handshake bundle for the serial inverse subtractor: S/A in, B/err out.
interface sub4u_serial_inverse_if;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] s;
    logic [3:0] a;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] b;
    logic       err;

    // Block side: consumes S/A, produces B/err.
    modport slave (
        input  in_valid, s, a, out_ready,
        output in_ready, out_valid, b, err
    );

    // Environment side: produces S/A, consumes B/err.
    modport master (
        output in_valid, s, a, out_ready,
        input  in_ready, out_valid, b, err
    );
endinterface

// File: rtl/sub4u_serial_inverse.sv
// Bit-serial B = S - A recovery for checking a 4-bit unsigned adder.
// Five LSB-first borrow-ripple steps; err flags sums no 4-bit B can produce.
//
// state | meaning
// IDLE  | waiting for S/A, in_ready high
// SHIFT | one difference bit per clock, cnt counts 0..4
// DONE  | b/err valid, held until the consumer takes them
module sub4u_serial_inverse (
    input  logic                         clk,
    input  logic                         rst_n,
    sub4u_serial_inverse_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] sr_q, sr_d;
    logic [4:0] ar_q, ar_d;
    logic [4:0] rr_q, rr_d;
    logic       borrow_q, borrow_d;
    logic [2:0] cnt_q, cnt_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] b_q, b_d;
    logic       err_q, err_d;

    logic       diff_bit;
    logic       borrow_nx;
    logic [4:0] rr_shift;

    // One full-subtractor step on the current LSBs.
    assign diff_bit  = sr_q[0] ^ ar_q[0] ^ borrow_q;
    assign borrow_nx = (~sr_q[0] & ar_q[0]) | (~(sr_q[0] ^ ar_q[0]) & borrow_q);
    assign rr_shift  = {diff_bit, rr_q[4:1]};

    // Next-state and next-output computation for the handshake FSM.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        ar_d        = ar_q;
        rr_d        = rr_q;
        borrow_d    = borrow_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        b_d         = b_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sr_d       = bus.s;
                    ar_d       = {1'b0, bus.a};
                    borrow_d   = 1'b0;
                    cnt_d      = 3'd0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                rr_d     = rr_shift;
                sr_d     = {1'b0, sr_q[4:1]};
                ar_d     = {1'b0, ar_q[4:1]};
                borrow_d = borrow_nx;
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd4) begin
                    // Final borrow means S < A; a set MSB means S - A >= 16.
                    b_d         = rr_shift[3:0];
                    err_d       = borrow_nx | rr_shift[4];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // b/err are deliberately left holding their value after transfer.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= 5'd0;
            ar_q        <= 5'd0;
            rr_q        <= 5'd0;
            borrow_q    <= 1'b0;
            cnt_q       <= 3'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            b_q         <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            ar_q        <= ar_d;
            rr_q        <= rr_d;
            borrow_q    <= borrow_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            b_q         <= b_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.b         = b_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_sub4u_serial_inverse.sv
// Bench for sub4u_serial_inverse: directed cases plus randomized S/A and backpressure.
module tb_sub4u_serial_inverse;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    sub4u_serial_inverse_if bus ();

    sub4u_serial_inverse dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees.
    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction of the unsigned operands.
    function automatic int ref_b(input int s, input int a);
        return ((s - a) % 16 + 16) % 16;
    endfunction

    function automatic int ref_err(input int s, input int a);
        return ((s < a) || (s - a > 15)) ? 1 : 0;
    endfunction

    // Scribble on the input side while the block should be ignoring it.
    task automatic noise();
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.s        = 5'($urandom);
        bus.a        = 4'($urandom);
    endtask

    // Full transaction: accept, latency check, optional backpressure, transfer.
    task automatic txn(input int s, input int a, input int hold);
        int n;
        int eb;
        int ee;
        eb = ref_b(s, a);
        ee = ref_err(s, a);

        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", int'(bus.in_ready), 1);

        bus.in_valid  = 1'b1;
        bus.s         = 5'(s);
        bus.a         = 4'(a);
        bus.out_ready = (hold == 0);
        @(negedge clk);
        chk("in_ready_after_accept", int'(bus.in_ready), 0);
        noise();

        n = 1;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            noise();
            n++;
        end
        chk("latency", n, 6);
        chk("b", int'(bus.b), eb);
        chk("err", int'(bus.err), ee);

        for (int i = 0; i < hold; i++) begin
            chk("hold_out_valid", int'(bus.out_valid), 1);
            chk("hold_in_ready", int'(bus.in_ready), 0);
            chk("hold_b", int'(bus.b), eb);
            chk("hold_err", int'(bus.err), ee);
            @(negedge clk);
            noise();
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("out_valid_drop", int'(bus.out_valid), 0);
        chk("in_ready_return", int'(bus.in_ready), 1);
        chk("b_kept_after_done", int'(bus.b), eb);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.s         = 5'd0;
        bus.a         = 4'd0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_b", int'(bus.b), 0);
        chk("rst_err", int'(bus.err), 0);
        rst_n = 1'b1;

        txn(19, 7, 0);
        txn(30, 15, 0);
        txn(0, 0, 0);
        txn(3, 9, 0);
        txn(20, 2, 1);
        txn(10, 4, 8);
        txn(27, 5, 0);

        // Abort two cycles into SHIFT; b is nonzero beforehand so the clear is visible.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.s        = 5'd25;
        bus.a        = 4'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        chk("midrst_b", int'(bus.b), 0);
        chk("midrst_err", int'(bus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(16, 1, 0);

        for (int i = 0; i < 60; i++) begin
            txn(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
